data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64; number of 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter ADDR_W, default 32; byte-address width.
REQ-003 SHALL have parameter INIT_VAL, default 32'd8; value written to every word by the init sweep.
REQ-004 SHALL have port clk, input, 1; the single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1; request present.
REQ-007 SHALL have port req_ready, output, 1; request accepted when req_valid and req_ready are both high at a rising edge.
REQ-008 SHALL have port req_we, input, 1; 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, ADDR_W; byte address.
REQ-010 SHALL have port req_wdata, input, 32; store data, right-aligned.
REQ-011 SHALL have port req_size, input, 2; 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL have port req_unsigned, input, 1; load zero-extends when 1 and sign-extends when 0.
REQ-013 SHALL have port rsp_valid, output, 1; response present.
REQ-014 SHALL have port rsp_ready, input, 1; response consumed when rsp_valid and rsp_ready are both high at a rising edge.
REQ-015 SHALL have port rsp_rdata, output, 32; load result; 0 for stores and errors.
REQ-016 SHALL have port rsp_err, output, 1; misaligned, out-of-range or illegal-size request.
REQ-017 SHALL have port init_done, output, 1; high once the init sweep has completed.

Function
REQ-018 SHALL derive word index = req_addr[AW+1:2] and lane = req_addr[1:0], where AW = clog2(DEPTH).
REQ-019 SHALL implement states INIT, IDLE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 INIT SHALL write INIT_VAL to one word per cycle, indices 0 to DEPTH-1; after index DEPTH-1 it SHALL go to IDLE and set init_done=1.
REQ-021 Acceptance in IDLE SHALL go to RESP; rsp_valid SHALL be high exactly one cycle after acceptance (1-cycle latency).
REQ-022 RESP SHALL hold rsp_valid, rsp_rdata and rsp_err stable until the rsp_ready handshake, then return to IDLE; at most one request SHALL be outstanding.
REQ-023 SHALL flag rsp_err=1 for any of:
  - req_size=11
  - half-word access with lane[0]=1
  - word access with lane!=0
  - req_addr[ADDR_W-1:AW+2] nonzero
REQ-024 An errored request SHALL not modify memory and SHALL return rsp_rdata=0.
REQ-025 A store SHALL write at the acceptance edge with byte-enable merge:
  - byte: req_wdata[7:0] into byte lane
  - half: req_wdata[15:0] into lanes {lane+1, lane}
  - word: all 32 bits
  - unaddressed bytes unchanged
REQ-026 A load SHALL read the addressed word at acceptance, extract the addressed byte or half, and extend it to 32 bits per req_unsigned; a word load SHALL ignore req_unsigned.
REQ-027 A load issued immediately after a store to the same word SHALL return the post-store value.
REQ-028 Inputs SHALL be ignored when req_ready=0; req_valid during INIT or RESP SHALL not be accepted.

Reset
REQ-029 Asserting reset (low) SHALL immediately force state=INIT, init index=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0, independent of clk.
REQ-030 Reset mid-RESP SHALL drop the pending response; reset mid-INIT SHALL restart the sweep from index 0.
REQ-031 A store in progress at reset SHALL have no required memory effect; the init sweep overwrites all words.

Verification
REQ-032 Release reset and idle -> init_done=0 for exactly DEPTH cycles, then 1; a word load from 0x0 returns 0x00000008.
REQ-033 Store word 0xDEADBEEF at 0x10; load byte 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half 0x10 signed -> 0xFFFFBEEF.
REQ-034 Store byte 0xA5 at 0x21 over INIT_VAL -> word load 0x20 returns 0x0000A508.
REQ-035 Half load at 0x03, word store at 0x06, access at byte address DEPTH*4 -> each gives rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-036 Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and data stable, req_ready=0 and new req_valid not accepted; a single rsp_ready=1 cycle -> IDLE.
REQ-037 Assert reset during RESP and again mid-INIT -> rsp_valid falls asynchronously, init restarts from index 0, full DEPTH-cycle sweep before init_done.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - word-organised data memory with init sweep, byte/half/word access and one-deep response
module data_memory_ctrl #(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] INIT_VAL = 32'd8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   init_idx;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic            accept;
    logic            err;
    logic [31:0]     rd_word;
    logic [31:0]     rd_sh;
    logic [31:0]     load_val;
    logic [31:0]     wr_sh;
    logic [3:0]      be;
    logic [31:0]     wr_word;

    assign idx     = req_addr[AW+1:2];
    assign lane    = req_addr[1:0];
    assign accept  = req_valid && (state == S_IDLE);
    assign rd_word = mem[idx];
    assign rd_sh   = rd_word >> {lane, 3'b000};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_idx == AW'(DEPTH - 1)) state_nxt = S_IDLE;
            S_IDLE:  if (req_valid) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    // High address bits beyond the array are decoded as out-of-range rather than aliased.
    always_comb begin
        err = 1'b0;
        case (req_size)
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            2'b11:   err = 1'b1;
            default: err = 1'b0;
        endcase
        if ((req_addr >> (AW + 2)) != '0) err = 1'b1;
    end

    always_comb begin
        case (req_size)
            2'b00:   load_val = req_unsigned ? {24'd0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
            2'b01:   load_val = req_unsigned ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select the target bytes.
    always_comb begin
        case (req_size)
            2'b00:   begin wr_sh = {4{req_wdata[7:0]}};  be = 4'b0001 << lane; end
            2'b01:   begin wr_sh = {2{req_wdata[15:0]}}; be = 4'b0011 << lane; end
            default: begin wr_sh = req_wdata;            be = 4'b1111;         end
        endcase
        wr_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) wr_word[8*b +: 8] = wr_sh[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_idx  <= '0;
            init_done <= 1'b0;
        end else if (state == S_INIT) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == AW'(DEPTH - 1)) init_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            rsp_rdata <= (err || req_we) ? 32'd0 : load_val;
            rsp_err   <= err;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_idx] <= INIT_VAL;
        end else if (accept && req_we && !err) begin
            mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - table, corner-sequence and randomized model checks for data_memory_ctrl
module tb_data_memory_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mb [DEPTH*4];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_VAL(32'd8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < DEPTH; i++) begin
            mb[4*i] = 8'h08; mb[4*i+1] = 8'h00; mb[4*i+2] = 8'h00; mb[4*i+3] = 8'h00;
        end
    endfunction

    // Byte-addressed memory: any legal access is n consecutive bytes, little-endian.
    function automatic void model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [1:0] size, input logic uns,
                                      output logic [31:0] exp_rdata, output logic exp_err);
        int n;
        logic [31:0] v;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        if (size == 2'b11) begin
            exp_err = 1'b1;
            return;
        end
        n = 1 << size;
        if ((addr % n) != 0 || addr >= DEPTH*4) begin
            exp_err = 1'b1;
            return;
        end
        if (we) begin
            for (int b = 0; b < n; b++) mb[addr + b] = wdata[8*b +: 8];
        end else begin
            v = 32'd0;
            for (int b = 0; b < n; b++) v[8*b +: 8] = mb[addr + b];
            if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            exp_rdata = v;
        end
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns,
                          output logic [31:0] rdata, output logic err);
        @(negedge clk);
        rsp_ready    = 1'b1;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        wait_ready("req");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rsp_latency", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic release_and_count(input string name);
        int cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        while (!init_done && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check(name, cnt, DEPTH);
        model_init();
    endtask

    initial begin
        logic [31:0] rd, exp_rd, a, held;
        logic        er, exp_er;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b1;

        vecs[0]  = '{1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 32'h0000_0008, 1'b0};
        vecs[1]  = '{1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0};
        vecs[3]  = '{1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 32'h0000_00DE, 1'b0};
        vecs[4]  = '{1'b0, 32'h10, 32'h0,        2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 32'h0000_DEAD, 1'b0};
        vecs[6]  = '{1'b1, 32'h21, 32'h1234_56A5, 2'b00, 1'b0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h20, 32'h0,        2'b10, 1'b1, 32'h0000_A508, 1'b0};
        vecs[8]  = '{1'b0, 32'h03, 32'h0,        2'b01, 1'b0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h06, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h04, 32'h0,        2'b10, 1'b0, 32'h0000_0008, 1'b0};
        vecs[11] = '{1'b1, DEPTH*4, 32'h5555_5555, 2'b00, 1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, DEPTH*4, 32'h0,       2'b10, 1'b0, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b1, 32'h00, 32'h7777_7777, 2'b11, 1'b0, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b0, 32'h00, 32'h0,        2'b10, 1'b0, 32'h0000_0008, 1'b0};

        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_init_done", {31'd0, init_done}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        #20;
        release_and_count("init_cycles");

        foreach (vecs[i]) begin
            model_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, exp_rd, exp_er);
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, rd, er);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        end

        // Backpressure: response held, a competing store must be ignored.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        wait_ready("bp");
        @(posedge clk);
        #1;
        req_we = 1'b1; req_wdata = 32'h0; held = rsp_rdata;
        check("bp_first_data", held, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_back_idle", {31'd0, req_ready}, 32'd1);
        check("bp_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er);
        check("bp_store_ignored", rd, 32'hDEADBEEF);

        for (int i = 0; i < 300; i++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [31:0] wd;
            a = $urandom_range(0, DEPTH*4 + 15);
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
            we  = $urandom_range(0, 1);
            uns = $urandom_range(0, 1);
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            model_req(we, a, wd, sz, uns, exp_rd, exp_er);
            do_req(we, a, wd, sz, uns, rd, er);
            check($sformatf("rand%0d_rdata@%08h", i, a), rd, exp_rd);
            check($sformatf("rand%0d_err@%08h", i, a), {31'd0, er}, {31'd0, exp_er});
        end

        // Reset in RESP, then again part-way through the sweep.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = 2'b10;
        wait_ready("rr");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rr_pending", {31'd0, rsp_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rr_rsp_valid_async", {31'd0, rsp_valid}, 32'd0);
        check("rr_req_ready", {31'd0, req_ready}, 32'd0);
        check("rr_init_done", {31'd0, init_done}, 32'd0);
        check("rr_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1; rsp_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_init_not_done", {31'd0, init_done}, 32'd0);
        #1 reset = 1'b0;
        #1;
        check("mid_init_reset_done", {31'd0, init_done}, 32'd0);
        release_and_count("reinit_cycles");
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, er);
        check("reinit_word10", rd, 32'h0000_0008);
        do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, er);
        check("reinit_word20", rd, 32'h0000_0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
